// File: rtl/multi_box_overlay.sv
// Draws up to NUM_BOXES hollow, per-box coloured rectangles over a streaming RGB pixel stream.
// Geometry is written into a shadow table and committed to the active table at frame start.
module multi_box_overlay #(
  parameter int NUM_BOXES  = 4,
  parameter int COORD_W    = 11,
  parameter int THICK      = 2,
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int IDX_W      = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [23:0]        cfg_color,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] vga_x,
  input  logic [COORD_W-1:0] vga_y,
  input  logic [23:0]        din,
  output logic               dout_valid,
  output logic [23:0]        dout
);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] bottom;
    logic [23:0]        color;
  } box_t;

  localparam logic [COORD_W:0] X_MAX = (COORD_W+1)'(IMG_WIDTH - 1);
  localparam logic [COORD_W:0] Y_MAX = (COORD_W+1)'(IMG_HEIGHT - 1);
  localparam logic [COORD_W:0] TH    = (COORD_W+1)'(THICK);

  box_t shd [NUM_BOXES];
  box_t act [NUM_BOXES];
  box_t new_box;

  logic [COORD_W-1:0] half_w, half_h;
  logic [COORD_W:0]   sum_r, sum_b;

  // Edges are derived at write time so the pixel path only compares.
  always_comb begin
    half_w        = cfg_w >> 1;
    half_h        = cfg_h >> 1;
    sum_r         = {1'b0, cfg_x} + {1'b0, half_w};
    sum_b         = {1'b0, cfg_y} + {1'b0, half_h};
    new_box       = '0;
    new_box.en    = cfg_en;
    new_box.color = cfg_color;
    new_box.left  = (cfg_x < half_w) ? '0 : cfg_x - half_w;
    new_box.top   = (cfg_y < half_h) ? '0 : cfg_y - half_h;
    new_box.right = (sum_r > X_MAX) ? X_MAX[COORD_W-1:0] : sum_r[COORD_W-1:0];
    new_box.bottom = (sum_b > Y_MAX) ? Y_MAX[COORD_W-1:0] : sum_b[COORD_W-1:0];
  end

  // Commit copies the pre-write shadow: both updates use the values sampled this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BOXES; i++) begin
        shd[i] <= '0;
        act[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BOXES; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i)) && (32'(cfg_idx) < 32'(NUM_BOXES)))
          shd[i] <= new_box;
        if (frame_start)
          act[i] <= shd[i];
      end
    end
  end

  logic [NUM_BOXES-1:0] hit, hit_q;
  logic [COORD_W:0]     xe, ye;

  always_comb begin
    xe  = {1'b0, vga_x};
    ye  = {1'b0, vga_y};
    hit = '0;
    for (int unsigned i = 0; i < NUM_BOXES; i++) begin
      hit[i] = act[i].en &&
               (xe >= {1'b0, act[i].left}) && (xe <= {1'b0, act[i].right}) &&
               (ye >= {1'b0, act[i].top})  && (ye <= {1'b0, act[i].bottom}) &&
               ((xe < {1'b0, act[i].left} + TH) || (xe + TH > {1'b0, act[i].right}) ||
                (ye < {1'b0, act[i].top} + TH)  || (ye + TH > {1'b0, act[i].bottom}));
    end
  end

  logic [23:0] din_q, mux;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q   <= '0;
      din_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      hit_q   <= hit;
      din_q   <= din;
      valid_q <= pix_valid;
    end
  end

  // Scanning from the top index down leaves the lowest hitting index as the winner.
  always_comb begin
    mux = din_q;
    for (int unsigned i = NUM_BOXES; i > 0; i--) begin
      if (hit_q[i-1])
        mux = act[i-1].color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= valid_q;
      if (valid_q)
        dout <= mux;
    end
  end

endmodule
